// File: rtl/qbus_reply_if.sv
// Bus-side signal bundle between the CPU bus interface and the qbus_reply responder.
// The master side drives the CPU strobes and the external device reply; the slave side answers.
interface qbus_reply_if;
    logic        ce;
    logic        sync;
    logic        din;
    logic        dout;
    logic        wtbt;
    logic [15:0] addr;
    logic        rply;
    logic        berr;
    logic        ram_ce;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [14:0] ram_addr;
    logic        sel1;
    logic        sel2;
    logic        ext_sel;
    logic        ext_rply;

    modport master (
        output ce, sync, din, dout, wtbt, addr, ext_rply,
        input  rply, berr, ram_ce, ram_we, ram_be, ram_addr, sel1, sel2, ext_sel
    );

    modport slave (
        input  ce, sync, din, dout, wtbt, addr, ext_rply,
        output rply, berr, ram_ce, ram_we, ram_be, ram_addr, sel1, sel2, ext_sel
    );
endinterface

// File: rtl/qbus_reply.sv
// Bus responder: decodes each access as RAM, system register, I/O page or unmapped,
// issues the matching strobe, then answers with RPLY or flags a bus error on timeout.
module qbus_reply #(
    parameter logic [15:0] RAM_TOP     = 16'o100000,
    parameter logic [15:0] IO_BASE     = 16'o177600,
    parameter int unsigned RAM_WAIT    = 1,
    parameter int unsigned BUS_TIMEOUT = 63
) (
    input logic         clk,
    input logic         reset,
    qbus_reply_if.slave bus
);
    localparam logic [15:0] SEL1_ADDR = 16'o177716;
    localparam logic [15:0] SEL2_ADDR = 16'o177714;
    localparam logic [2:0]  WAIT_LOAD = 3'(RAM_WAIT);
    localparam logic [7:0]  TMO_LOAD  = 8'(BUS_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM,
        S_SEL,
        S_EXT,
        S_REPLY,
        S_ERROR
    } state_t;

    state_t      r_state;
    logic        r_syncQ;
    logic [7:0]  r_tmo;
    logic [2:0]  r_wait;
    logic        r_rply;
    logic        r_berr;
    logic        r_ramCe;
    logic        r_ramWe;
    logic [1:0]  r_ramBe;
    logic [14:0] r_ramAddr;
    logic        r_sel1;
    logic        r_sel2;
    logic        r_extSel;

    logic        w_syncRise;
    logic [1:0]  w_be;
    logic [7:0]  w_tmoNext;

    assign w_syncRise = bus.sync & ~r_syncQ;
    assign w_be       = (bus.wtbt & bus.dout) ? (bus.addr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign w_tmoNext  = (r_tmo == 8'd0) ? 8'd0 : r_tmo - 8'd1;

    // Reset leaves r_syncQ high so a sync already asserted during reset cannot start an access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_syncQ   <= 1'b1;
            r_tmo     <= TMO_LOAD;
            r_wait    <= 3'd0;
            r_rply    <= 1'b0;
            r_berr    <= 1'b0;
            r_ramCe   <= 1'b0;
            r_ramWe   <= 1'b0;
            r_ramBe   <= 2'b00;
            r_ramAddr <= 15'd0;
            r_sel1    <= 1'b0;
            r_sel2    <= 1'b0;
            r_extSel  <= 1'b0;
        end else if (bus.ce) begin
            r_syncQ <= bus.sync;
            case (r_state)
                S_IDLE: begin
                    if (w_syncRise && bus.din && bus.dout) begin
                        r_state <= S_ERROR;
                        r_berr  <= 1'b1;
                    end else if (w_syncRise && (bus.din ^ bus.dout)) begin
                        r_tmo <= TMO_LOAD;
                        if (bus.addr < RAM_TOP) begin
                            r_state   <= S_RAM;
                            r_ramCe   <= 1'b1;
                            r_ramWe   <= bus.dout;
                            r_ramBe   <= w_be;
                            r_ramAddr <= bus.addr[15:1];
                            r_wait    <= WAIT_LOAD;
                        end else if (bus.addr[15:1] == SEL1_ADDR[15:1]) begin
                            r_state <= S_SEL;
                            r_sel1  <= 1'b1;
                        end else if (bus.addr[15:1] == SEL2_ADDR[15:1]) begin
                            r_state <= S_SEL;
                            r_sel2  <= 1'b1;
                        end else if (bus.addr >= IO_BASE) begin
                            r_state  <= S_EXT;
                            r_extSel <= 1'b1;
                        end else begin
                            r_state <= S_EXT;
                        end
                    end
                end
                S_RAM: begin
                    r_ramCe <= 1'b0;
                    if (!bus.sync) begin
                        r_state <= S_IDLE;
                        r_ramWe <= 1'b0;
                        r_ramBe <= 2'b00;
                    end else if (r_wait == 3'd0) begin
                        r_state <= S_REPLY;
                        r_rply  <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                S_SEL: begin
                    if (!bus.sync) begin
                        r_state <= S_IDLE;
                        r_sel1  <= 1'b0;
                        r_sel2  <= 1'b0;
                    end else begin
                        r_state <= S_REPLY;
                        r_rply  <= 1'b1;
                    end
                end
                // A reply arriving on the same edge the counter expires still wins.
                S_EXT: begin
                    if (!bus.sync) begin
                        r_state  <= S_IDLE;
                        r_extSel <= 1'b0;
                    end else if (bus.ext_rply) begin
                        r_state <= S_REPLY;
                        r_rply  <= 1'b1;
                    end else begin
                        r_tmo <= w_tmoNext;
                        if (w_tmoNext == 8'd0) begin
                            r_state <= S_ERROR;
                            r_berr  <= 1'b1;
                        end
                    end
                end
                S_REPLY, S_ERROR: begin
                    if (!bus.sync) begin
                        r_state  <= S_IDLE;
                        r_rply   <= 1'b0;
                        r_berr   <= 1'b0;
                        r_ramWe  <= 1'b0;
                        r_ramBe  <= 2'b00;
                        r_sel1   <= 1'b0;
                        r_sel2   <= 1'b0;
                        r_extSel <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rply     = r_rply;
    assign bus.berr     = r_berr;
    assign bus.ram_ce   = r_ramCe;
    assign bus.ram_we   = r_ramWe;
    assign bus.ram_be   = r_ramBe;
    assign bus.ram_addr = r_ramAddr;
    assign bus.sel1     = r_sel1;
    assign bus.sel2     = r_sel2;
    assign bus.ext_sel  = r_extSel;
endmodule

// File: tb/tb_qbus_reply.sv
// Directed testbench for qbus_reply with default parameters (RAM_WAIT=1, BUS_TIMEOUT=63).
// Each scenario task drives the bus and compares outputs against hand-computed values.
module tb_qbus_reply;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    qbus_reply_if busIf();

    qbus_reply dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the edge, and new inputs are applied at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic endAccess();
        busIf.sync = 1'b0; busIf.din = 1'b0; busIf.dout = 1'b0; busIf.wtbt = 1'b0; busIf.ext_rply = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busIf.ce = 1'b1; busIf.sync = 1'b0; busIf.din = 1'b0; busIf.dout = 1'b0;
        busIf.wtbt = 1'b0; busIf.addr = 16'd0; busIf.ext_rply = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (busIf.rply !== 1'b0) begin errors++; $display("[TB] FAIL reset.rply got %b exp 0", busIf.rply); end
        checks++; if (busIf.berr !== 1'b0) begin errors++; $display("[TB] FAIL reset.berr got %b exp 0", busIf.berr); end
        checks++; if ({busIf.ram_ce, busIf.ram_we, busIf.ram_be, busIf.sel1, busIf.sel2, busIf.ext_sel} !== 7'b0) begin
            errors++; $display("[TB] FAIL reset.strobes got %b exp 0000000",
                {busIf.ram_ce, busIf.ram_we, busIf.ram_be, busIf.sel1, busIf.sel2, busIf.ext_sel});
        end
        busIf.addr = 16'o001000; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if (busIf.ram_ce !== 1'b1) begin errors++; $display("[TB] FAIL resetMid.strobe got %b exp 1", busIf.ram_ce); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busIf.rply, busIf.berr, busIf.ram_ce} !== 3'b000) begin
            errors++; $display("[TB] FAIL resetMid.abort got %b exp 000", {busIf.rply, busIf.berr, busIf.ram_ce});
        end
        tick(); tick(); tick();
        checks++; if ({busIf.rply, busIf.berr, busIf.ram_ce} !== 3'b000) begin
            errors++; $display("[TB] FAIL resetMid.noRestart got %b exp 000", {busIf.rply, busIf.berr, busIf.ram_ce});
        end
        endAccess();
    endtask

    task automatic test_ram_read();
        busIf.addr = 16'o001000; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if (busIf.ram_ce !== 1'b1) begin errors++; $display("[TB] FAIL ramRead.ce got %b exp 1", busIf.ram_ce); end
        checks++; if (busIf.ram_addr !== 15'o000400) begin errors++; $display("[TB] FAIL ramRead.addr got %o exp 400", busIf.ram_addr); end
        checks++; if ({busIf.ram_we, busIf.ram_be} !== 3'b011) begin
            errors++; $display("[TB] FAIL ramRead.weBe got %b exp 011", {busIf.ram_we, busIf.ram_be});
        end
        tick();
        checks++; if ({busIf.ram_ce, busIf.rply} !== 2'b00) begin
            errors++; $display("[TB] FAIL ramRead.wait got %b exp 00", {busIf.ram_ce, busIf.rply});
        end
        tick();
        checks++; if (busIf.rply !== 1'b1) begin errors++; $display("[TB] FAIL ramRead.rply got %b exp 1", busIf.rply); end
        busIf.din = 1'b0;
        tick();
        checks++; if (busIf.rply !== 1'b1) begin errors++; $display("[TB] FAIL ramRead.rplyHold got %b exp 1", busIf.rply); end
        busIf.sync = 1'b0;
        tick();
        checks++; if (busIf.rply !== 1'b0) begin errors++; $display("[TB] FAIL ramRead.rplyDrop got %b exp 0", busIf.rply); end
        endAccess();
    endtask

    task automatic test_byte_write();
        busIf.addr = 16'o000777; busIf.dout = 1'b1; busIf.wtbt = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.ram_ce, busIf.ram_we, busIf.ram_be} !== 4'b1110) begin
            errors++; $display("[TB] FAIL byteHi.ceWeBe got %b exp 1110", {busIf.ram_ce, busIf.ram_we, busIf.ram_be});
        end
        checks++; if (busIf.ram_addr !== 15'o000377) begin errors++; $display("[TB] FAIL byteHi.addr got %o exp 377", busIf.ram_addr); end
        tick(); tick();
        checks++; if (busIf.rply !== 1'b1) begin errors++; $display("[TB] FAIL byteHi.rply got %b exp 1", busIf.rply); end
        endAccess();
        busIf.addr = 16'o000776; busIf.dout = 1'b1; busIf.wtbt = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.ram_ce, busIf.ram_we, busIf.ram_be} !== 4'b1101) begin
            errors++; $display("[TB] FAIL byteLo.ceWeBe got %b exp 1101", {busIf.ram_ce, busIf.ram_we, busIf.ram_be});
        end
        checks++; if (busIf.ram_addr !== 15'o000377) begin errors++; $display("[TB] FAIL byteLo.addr got %o exp 377", busIf.ram_addr); end
        endAccess();
    endtask

    task automatic test_sel();
        busIf.addr = 16'o177716; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.sel1, busIf.sel2, busIf.rply, busIf.ram_ce} !== 4'b1000) begin
            errors++; $display("[TB] FAIL sel1.start got %b exp 1000", {busIf.sel1, busIf.sel2, busIf.rply, busIf.ram_ce});
        end
        tick();
        checks++; if ({busIf.sel1, busIf.rply} !== 2'b11) begin
            errors++; $display("[TB] FAIL sel1.rply got %b exp 11", {busIf.sel1, busIf.rply});
        end
        busIf.sync = 1'b0; busIf.din = 1'b0;
        tick();
        checks++; if ({busIf.sel1, busIf.rply} !== 2'b00) begin
            errors++; $display("[TB] FAIL sel1.clear got %b exp 00", {busIf.sel1, busIf.rply});
        end
        tick();
        busIf.addr = 16'o177714; busIf.dout = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.sel1, busIf.sel2, busIf.rply} !== 3'b010) begin
            errors++; $display("[TB] FAIL sel2.start got %b exp 010", {busIf.sel1, busIf.sel2, busIf.rply});
        end
        tick();
        checks++; if ({busIf.sel2, busIf.rply} !== 2'b11) begin
            errors++; $display("[TB] FAIL sel2.rply got %b exp 11", {busIf.sel2, busIf.rply});
        end
        busIf.sync = 1'b0; busIf.dout = 1'b0;
        tick();
        checks++; if ({busIf.sel2, busIf.rply} !== 2'b00) begin
            errors++; $display("[TB] FAIL sel2.clear got %b exp 00", {busIf.sel2, busIf.rply});
        end
        tick();
    endtask

    task automatic test_timeout();
        logic earlyErr;
        earlyErr = 1'b0;
        busIf.addr = 16'o150000; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.ext_sel, busIf.ram_ce, busIf.sel1, busIf.sel2} !== 4'b0000) begin
            errors++; $display("[TB] FAIL unmapped.strobes got %b exp 0000", {busIf.ext_sel, busIf.ram_ce, busIf.sel1, busIf.sel2});
        end
        for (int i = 0; i < 62; i++) begin
            tick();
            if (busIf.berr !== 1'b0 || busIf.rply !== 1'b0) earlyErr = 1'b1;
        end
        checks++; if (earlyErr !== 1'b0) begin errors++; $display("[TB] FAIL unmapped.early got %b exp 0", earlyErr); end
        tick();
        checks++; if ({busIf.berr, busIf.rply} !== 2'b10) begin
            errors++; $display("[TB] FAIL unmapped.berr got %b exp 10", {busIf.berr, busIf.rply});
        end
        busIf.sync = 1'b0; busIf.din = 1'b0;
        tick();
        checks++; if (busIf.berr !== 1'b0) begin errors++; $display("[TB] FAIL unmapped.clear got %b exp 0", busIf.berr); end
        tick();
    endtask

    task automatic test_ext_reply();
        busIf.addr = 16'o177600; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if (busIf.ext_sel !== 1'b1) begin errors++; $display("[TB] FAIL ext.sel got %b exp 1", busIf.ext_sel); end
        for (int i = 0; i < 9; i++) tick();
        busIf.ext_rply = 1'b1;
        tick();
        busIf.ext_rply = 1'b0;
        checks++; if ({busIf.rply, busIf.berr, busIf.ext_sel} !== 3'b101) begin
            errors++; $display("[TB] FAIL ext.rply got %b exp 101", {busIf.rply, busIf.berr, busIf.ext_sel});
        end
        busIf.sync = 1'b0; busIf.din = 1'b0;
        tick();
        checks++; if ({busIf.rply, busIf.ext_sel} !== 2'b00) begin
            errors++; $display("[TB] FAIL ext.clear got %b exp 00", {busIf.rply, busIf.ext_sel});
        end
        tick();
    endtask

    task automatic test_collision();
        busIf.addr = 16'o000100; busIf.din = 1'b1; busIf.dout = 1'b1; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.berr, busIf.rply, busIf.ram_ce} !== 3'b100) begin
            errors++; $display("[TB] FAIL collision.berr got %b exp 100", {busIf.berr, busIf.rply, busIf.ram_ce});
        end
        busIf.sync = 1'b0;
        tick();
        checks++; if (busIf.berr !== 1'b0) begin errors++; $display("[TB] FAIL collision.clear got %b exp 0", busIf.berr); end
        endAccess();
    endtask

    task automatic test_abort();
        busIf.addr = 16'o177600; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick(); tick(); tick();
        busIf.sync = 1'b0; busIf.din = 1'b0;
        tick();
        checks++; if ({busIf.rply, busIf.berr, busIf.ext_sel} !== 3'b000) begin
            errors++; $display("[TB] FAIL abort.idle got %b exp 000", {busIf.rply, busIf.berr, busIf.ext_sel});
        end
        for (int i = 0; i < 70; i++) tick();
        checks++; if ({busIf.rply, busIf.berr} !== 2'b00) begin
            errors++; $display("[TB] FAIL abort.quiet got %b exp 00", {busIf.rply, busIf.berr});
        end
    endtask

    task automatic test_ce_freeze();
        logic earlyErr;
        earlyErr = 1'b0;
        busIf.addr = 16'o150000; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) tick();
        busIf.ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busIf.berr !== 1'b0) earlyErr = 1'b1;
        end
        busIf.ce = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (busIf.berr !== 1'b0) earlyErr = 1'b1;
        end
        checks++; if (earlyErr !== 1'b0) begin errors++; $display("[TB] FAIL ceFreeze.early got %b exp 0", earlyErr); end
        tick();
        checks++; if (busIf.berr !== 1'b1) begin errors++; $display("[TB] FAIL ceFreeze.berr got %b exp 1", busIf.berr); end
        endAccess();
    endtask

    task automatic test_back_to_back();
        busIf.addr = 16'o177716; busIf.din = 1'b1; busIf.sync = 1'b1;
        tick(); tick();
        busIf.sync = 1'b0;
        tick();
        busIf.addr = 16'o000002; busIf.sync = 1'b1;
        tick();
        checks++; if ({busIf.ram_ce, busIf.ram_addr} !== {1'b1, 15'o000001}) begin
            errors++; $display("[TB] FAIL backToBack.ram got %b/%o exp 1/1", busIf.ram_ce, busIf.ram_addr);
        end
        busIf.din = 1'b0; busIf.dout = 1'b1;
        tick(); tick();
        checks++; if ({busIf.rply, busIf.ram_we} !== 2'b10) begin
            errors++; $display("[TB] FAIL backToBack.latchedDir got %b exp 10", {busIf.rply, busIf.ram_we});
        end
        endAccess();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ram_read();
        test_byte_write();
        test_sel();
        test_timeout();
        test_ext_reply();
        test_collision();
        test_abort();
        test_ce_freeze();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
